demux_32bit_1to2_pipe: RTL
==========================

DEMUX_32BIT_1TO2_PIPE -- requirements
Module: demux_32bit_1to2_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter CNT_WIDTH, default 16: width of each per-channel transfer counter.
REQ-003 Port Clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 Port Reset  input  1: synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 Port inData  input  WIDTH: word offered by the upstream stage.
REQ-006 Port inSel  input  1: destination select; 1 routes to channel A, 0 routes to channel B. Same polarity as the team's 2:1 mux, so A pairs with sel=1.
REQ-007 Port inValid  input  1: inData and inSel are valid this cycle.
REQ-008 Port inReady  output  1: block can accept a word this cycle; driven from registered state only.
REQ-009 Port outA  output  WIDTH: channel A data.
REQ-010 Port outAValid  output  1: outA holds a valid word.
REQ-011 Port outAReady  input  1: channel A consumer accepts outA this cycle.
REQ-012 Ports outB, outBValid, outBReady: same as REQ-009..011, for channel B.
REQ-013 Ports countA, countB  output  CNT_WIDTH: completed output transfers per channel.

Function
REQ-014 Input accept occurs on a rising edge with inValid=1 and inReady=1. Output transfer on channel X occurs on a rising edge with outXValid=1 and outXReady=1.
REQ-015 Each channel has one main register, which drives outX and outXValid, and one skid register with its own full flag.
REQ-016 inReady = NOT skidA_full AND NOT skidB_full. A stalled channel holding two words blocks both channels (head-of-line blocking accepted).
REQ-017 An accepted word goes to channel A when inSel=1 and to channel B when inSel=0. inSel and inData are don't-care when inValid=0.
REQ-018 Accepted word placement:
  - Goes to the selected channel's main register if that register is empty, or is being transferred out in the same cycle with the skid empty.
  - Otherwise goes to the skid register.
REQ-019 Latency: a word accepted at edge N appears on outX with outXValid=1 after edge N, i.e. one cycle. There is no combinational path from inData to outX.
REQ-020 On a channel X transfer with skid full, the skid word moves to main and skid_full clears in the same edge. outXValid stays 1 with no bubble.
REQ-021 On a channel X transfer with skid empty and no new word for X, outXValid goes to 0.
REQ-022 Simultaneous accept to X and transfer on X with skid empty: the new word loads main, outXValid stays 1, and throughput is one word per cycle.
REQ-023 Words destined for the same channel leave in acceptance order. Channels are independent in ordering.
REQ-024 outX and skid contents are unchanged while outXValid=1 and outXReady=0.
REQ-025 countX increments by 1 on each channel X transfer and wraps from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-026 The block never drops or duplicates a word.

Reset
REQ-027 While Reset=1 at a rising edge, the following take 0 after that edge: outAValid, outBValid, both skid flags, outA, outB, countA and countB. inReady becomes 1.
REQ-028 Reset overrides a simultaneous accept or transfer. Words held at reset are discarded, and no transfer is counted in that cycle.
REQ-029 inReady=1 holds from the first edge after Reset deasserts, if no word was accepted.

Verification
REQ-030 Reset, then one word 0xDEADBEEF with inSel=1 and both readies=1 -> outA=0xDEADBEEF with outAValid=1 for exactly one cycle, one cycle after accept; countA=1; outBValid stays 0.
REQ-031 Stream 0x1..0x8 alternating inSel=0,1 with readies=1 -> odd values appear on B in order and even values on A in order; countA=4, countB=4; inReady is held at 1.
REQ-032 outAReady=0, send 0xA1 then 0xA2 to A -> inReady=0 after the second accept; outA=0xA1 held; no B word is accepted. Then outAReady=1 -> 0xA1 then 0xA2 appear on back-to-back cycles and inReady returns to 1.
REQ-033 Continuous accept to B with outBReady=1 and skid empty -> one word per cycle, outBValid held at 1, no bubbles, countB matches the word count.
REQ-034 Preload countA to 0xFFFF via 65535 transfers, then one more transfer -> countA=0x0000.
REQ-035 Assert Reset while A holds two words and B holds one -> after that edge all valids=0, counts=0, inReady=1, and none of the held words ever appear.

Source files
------------

// File: rtl/demux_32bit_1to2_pipe_if.sv
// Bundle of the upstream port, both downstream channels and the transfer counters.
// The design plugs into the slave side, the driving environment into the master side.
interface demux_32bit_1to2_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     inData;
  logic                 inSel;
  logic                 inValid;
  logic                 inReady;
  logic [WIDTH-1:0]     outA;
  logic                 outAValid;
  logic                 outAReady;
  logic [WIDTH-1:0]     outB;
  logic                 outBValid;
  logic                 outBReady;
  logic [CNT_WIDTH-1:0] countA;
  logic [CNT_WIDTH-1:0] countB;

  modport slave (
    input  inData, inSel, inValid, outAReady, outBReady,
    output inReady, outA, outAValid, outB, outBValid, countA, countB
  );

  modport master (
    output inData, inSel, inValid, outAReady, outBReady,
    input  inReady, outA, outAValid, outB, outBValid, countA, countB
  );
endinterface

// File: rtl/demux_32bit_1to2_pipe.sv
// 1:2 registered demux with a main + skid register per channel and per-channel
// transfer counters. inSel=1 steers to channel A (lane 0), inSel=0 to channel B (lane 1).
module demux_32bit_1to2_pipe_ch #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_rdy,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_vld,
  output logic                 o_skid_full,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0]     r_main, r_skid;
  logic                 r_vld, r_skid_full;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_xfer;

  assign w_xfer = r_vld & i_rdy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_vld       <= 1'b0;
      r_skid_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_xfer) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_xfer) begin
        // Draining: skid refills main with no bubble, otherwise a new word goes straight to main.
        if (r_skid_full) begin
          r_main      <= r_skid;
          r_skid_full <= i_push;
          if (i_push) r_skid <= i_data;
        end else if (i_push) begin
          r_main <= i_data;
        end else begin
          r_vld <= 1'b0;
        end
      end else if (i_push) begin
        if (!r_vld) begin
          r_main <= i_data;
          r_vld  <= 1'b1;
        end else begin
          r_skid      <= i_data;
          r_skid_full <= 1'b1;
        end
      end
    end
  end

  assign o_data      = r_main;
  assign o_vld       = r_vld;
  assign o_skid_full = r_skid_full;
  assign o_cnt       = r_cnt;
endmodule

module demux_32bit_1to2_pipe #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  demux_32bit_1to2_pipe_if.slave     bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]                w_push, w_rdy, w_vld, w_skid_full;
  logic [NUM_LANES-1:0][WIDTH-1:0]     w_dout;
  logic [NUM_LANES-1:0][CNT_WIDTH-1:0] w_cnt;
  logic                                w_in_ready, w_acc;

  // Only skid flags feed inReady, so it never depends combinationally on the output readies.
  assign w_in_ready = ~|w_skid_full;
  assign w_acc      = bus.inValid & w_in_ready;
  assign w_push[0]  = w_acc &  bus.inSel;
  assign w_push[1]  = w_acc & ~bus.inSel;
  assign w_rdy[0]   = bus.outAReady;
  assign w_rdy[1]   = bus.outBReady;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_32bit_1to2_pipe_ch #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch (
      .Clk         (Clk),
      .Reset       (Reset),
      .i_push      (w_push[g]),
      .i_data      (bus.inData),
      .i_rdy       (w_rdy[g]),
      .o_data      (w_dout[g]),
      .o_vld       (w_vld[g]),
      .o_skid_full (w_skid_full[g]),
      .o_cnt       (w_cnt[g])
    );
  end

  assign bus.inReady   = w_in_ready;
  assign bus.outA      = w_dout[0];
  assign bus.outAValid = w_vld[0];
  assign bus.countA    = w_cnt[0];
  assign bus.outB      = w_dout[1];
  assign bus.outBValid = w_vld[1];
  assign bus.countB    = w_cnt[1];
endmodule
